// File: rtl/sort_ctrl.sv
// Block sorter: load N elements, run N odd-even transposition passes,
// then drain the sorted block one element per handshake.
module sort_ctrl #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  input  logic         desc,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  localparam int IW = $clog2(N);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_dir;
  logic [W-1:0]   r_a    [N];
  logic [W-1:0]   w_pass [N];
  logic [IW-1:0]  w_idx;
  logic           w_last;

  assign w_idx  = r_cnt[IW-1:0];
  assign w_last = (r_cnt == LAST);

  assign in_ready  = (r_state == LOAD);
  assign busy      = (r_state == SORT);
  assign out_valid = (r_state == DRAIN);
  assign out_data  = (r_state == DRAIN) ? r_a[w_idx] : '0;
  assign done      = (r_state == DRAIN) && out_ready && w_last;

  // Pairs within one pass are disjoint, so every swap reads the old array.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_pass[k] = r_a[k];
    end
    for (int k = 0; k < N - 1; k++) begin
      if (k[0] == r_cnt[0]) begin
        if (r_dir ? (r_a[k] < r_a[k+1])
                  : (r_a[k] > r_a[k+1])) begin
          w_pass[k]   = r_a[k+1];
          w_pass[k+1] = r_a[k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOAD;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      for (int k = 0; k < N; k++) begin
        r_a[k] <= '0;
      end
    end else begin
      unique case (r_state)
        LOAD: begin
          if (in_valid) begin
            r_a[w_idx] <= in_data;
            if (r_cnt == '0) begin
              r_dir <= desc;
            end
            if (w_last) begin
              r_state <= SORT;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        SORT: begin
          for (int k = 0; k < N; k++) begin
            r_a[k] <= w_pass[k];
          end
          if (w_last) begin
            r_state <= DRAIN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (w_last) begin
              r_state <= LOAD;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= LOAD;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_ctrl.sv
// Self-checking bench for sort_ctrl: directed blocks, randomized
// handshakes against a queue-based sorting model, and mid-sort reset.
module tb_sort_ctrl;

  localparam int N = 8;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         desc;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         busy;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_last  = 0;

  sort_ctrl #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .desc      (desc),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Reference: insertion into an ordered queue.
  function automatic void ref_sort(
    input  logic [W-1:0] src[$],
    input  bit           d,
    output logic [W-1:0] dst[$]
  );
    int p;
    dst = {};
    foreach (src[i]) begin
      p = dst.size();
      for (int j = 0; j < dst.size(); j++) begin
        if (d ? (src[i] > dst[j]) : (src[i] < dst[j])) begin
          p = j;
          break;
        end
      end
      dst.insert(p, src[i]);
    end
  endfunction

  // Drives one block; desc is set on the first beat and toggled after.
  task automatic load_block(
    input logic [W-1:0] d[$],
    input bit           dsc,
    input int           gap_pct
  );
    for (int i = 0; i < d.size(); i++) begin
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = d[i];
      desc     = (i == 0) ? dsc : ~desc;
      @(posedge clk);
      #1;
      t_last = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Collects one drained block and records handshake observations.
  task automatic drain_block(
    input  int           stall_pct,
    input  bit           junk,
    output logic [W-1:0] got[$],
    output int           lat,
    output int           busy_n,
    output int           bad_done,
    output int           unstable,
    output bit           tmo
  );
    bit           prev_stall;
    bit           exp_done;
    logic [W-1:0] prev_data;
    got = {};
    lat = -1;
    busy_n = 0;
    bad_done = 0;
    unstable = 0;
    prev_stall = 0;
    prev_data = '0;
    for (int c = 0; c < 300 && got.size() < N; c++) begin
      if (busy) busy_n++;
      if (out_valid && lat < 0) lat = cyc - t_last;
      if (out_valid && prev_stall && out_data !== prev_data)
        unstable++;
      out_ready = ($urandom_range(99) >= stall_pct);
      if (junk) begin
        in_valid = ($urandom_range(1) == 1);
        in_data  = W'($urandom);
      end
      if (out_valid && out_ready && got.size() == N - 1)
        in_valid = 1'b0;
      #1;
      exp_done = out_valid && out_ready && (got.size() == N - 1);
      if (done !== exp_done) bad_done++;
      if (out_valid && out_ready) got.push_back(out_data);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      @(negedge clk);
    end
    tmo = (got.size() < N);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    n_tests++;
    if (out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_out_data got=%0d exp=0", out_data);
    end
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_done got=%b%b exp=00", busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Directed block with a fixed expected result and fixed latency.
  task automatic test_directed(
    input string        name,
    input logic [W-1:0] d[$],
    input bit           dsc,
    input logic [W-1:0] exp[$]
  );
    logic [W-1:0] got[$];
    int lat, busy_n, bad_done, unstable;
    bit tmo;
    load_block(d, dsc, 0);
    drain_block(0, 0, got, lat, busy_n, bad_done, unstable, tmo);
    n_tests++;
    if (tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_timeout got=%0d elems exp=%0d", name,
               got.size(), N);
    end
    for (int i = 0; i < got.size(); i++) begin
      n_tests++;
      if (got[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL %s_out[%0d] got=%0d exp=%0d", name, i,
                 got[i], exp[i]);
      end
    end
    n_tests++;
    if (lat !== N) begin
      n_fail++;
      $display("FAIL %s_latency got=%0d exp=%0d", name, lat, N);
    end
    n_tests++;
    if (busy_n !== N) begin
      n_fail++;
      $display("FAIL %s_busy_cycles got=%0d exp=%0d", name,
               busy_n, N);
    end
    n_tests++;
    if (bad_done !== 0) begin
      n_fail++;
      $display("FAIL %s_done_pulse got=%0d bad exp=0", name, bad_done);
    end
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle got=%b%b%b exp=100", name,
               in_ready, out_valid, done);
    end
  endtask

  task automatic test_ascending;
    logic [W-1:0] d[$];
    logic [W-1:0] e[$];
    d = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4};
    e = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd7, 8'd8, 8'd9};
    test_directed("asc", d, 1'b0, e);
  endtask

  task automatic test_descending;
    logic [W-1:0] d[$];
    logic [W-1:0] e[$];
    d = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4};
    e = '{8'd9, 8'd8, 8'd7, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    test_directed("desc", d, 1'b1, e);
  endtask

  task automatic test_extremes;
    logic [W-1:0] d[$];
    logic [W-1:0] e[$];
    d = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd128, 8'd128, 8'd1, 8'd254};
    e = '{8'd0, 8'd0, 8'd1, 8'd128, 8'd128, 8'd254, 8'd255, 8'd255};
    test_directed("dup", d, 1'b0, e);
  endtask

  task automatic test_presorted;
    logic [W-1:0] d[$];
    logic [W-1:0] r[$];
    logic [W-1:0] e[$];
    d = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    r = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    e = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    test_directed("sorted", d, 1'b0, e);
    test_directed("reverse", r, 1'b0, e);
  endtask

  task automatic test_random;
    logic [W-1:0] d[$];
    logic [W-1:0] e[$];
    logic [W-1:0] got[$];
    int lat, busy_n, bad_done, unstable;
    bit tmo, dsc;
    for (int b = 0; b < 8; b++) begin
      d = {};
      for (int i = 0; i < N; i++)
        d.push_back((b % 2 == 0) ? W'($urandom_range(255))
                                 : W'($urandom_range(3)));
      dsc = ($urandom_range(1) == 1);
      ref_sort(d, dsc, e);
      load_block(d, dsc, 50);
      drain_block(50, 1, got, lat, busy_n, bad_done, unstable, tmo);
      n_tests++;
      if (tmo !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_timeout got=%0d elems exp=%0d", b,
                 got.size(), N);
      end
      for (int i = 0; i < got.size(); i++) begin
        n_tests++;
        if (got[i] !== e[i]) begin
          n_fail++;
          $display("FAIL rand%0d_out[%0d] got=%0d exp=%0d", b, i,
                   got[i], e[i]);
        end
      end
      n_tests++;
      if (lat !== N) begin
        n_fail++;
        $display("FAIL rand%0d_latency got=%0d exp=%0d", b, lat, N);
      end
      n_tests++;
      if (unstable !== 0) begin
        n_fail++;
        $display("FAIL rand%0d_stall_stable got=%0d changes exp=0",
                 b, unstable);
      end
      n_tests++;
      if (bad_done !== 0) begin
        n_fail++;
        $display("FAIL rand%0d_done_pulse got=%0d bad exp=0", b,
                 bad_done);
      end
    end
  endtask

  task automatic test_reset_mid_sort;
    logic [W-1:0] d[$];
    logic [W-1:0] r[$];
    logic [W-1:0] e[$];
    d = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4};
    r = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    e = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    load_block(d, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_busy_before got=%b exp=1", busy);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got=%b%b%b%b/%0d exp=1000/0",
               in_ready, out_valid, busy, done, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_directed("after_rst", r, 1'b0, e);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    desc      = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_ascending();
    test_descending();
    test_extremes();
    test_presorted();
    test_random();
    test_reset_mid_sort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sort_ctrl.md
SORT_CTRL -- requirements
Module: sort_ctrl

Interface
REQ-001 Parameter N, default 8, number of elements per block; N SHALL be even and at least 2.
REQ-002 Parameter W, default 8, element width in bits; elements SHALL be unsigned.
REQ-003 Port clk, input, 1 bit, single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit, asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1 bit, input element present on in_data.
REQ-006 Port in_data, input, W bits, input element.
REQ-007 Port in_ready, output, 1 bit, block accepts an input element this cycle.
REQ-008 Port desc, input, 1 bit, sort direction: 0 ascending, 1 descending; sampled only on the first accepted element of a block.
REQ-009 Port out_valid, output, 1 bit, sorted element present on out_data.
REQ-010 Port out_data, output, W bits, sorted element.
REQ-011 Port out_ready, input, 1 bit, downstream accepts out_data this cycle.
REQ-012 Port busy, output, 1 bit, high while sort passes run.
REQ-013 Port done, output, 1 bit, one-cycle pulse when the last element of a block is accepted downstream.

Function
REQ-014 The FSM SHALL have three states: LOAD, SORT, DRAIN; a shared counter cnt, width ceil(log2(N))+1, SHALL index elements in LOAD/DRAIN and passes in SORT.
REQ-015 LOAD: in_ready SHALL equal 1; each cycle with in_valid=1 SHALL store in_data into slot cnt and increment cnt.
REQ-016 LOAD, cnt=0 accept: desc SHALL be latched into an internal dir register that holds for the whole block.
REQ-017 LOAD, accept with cnt=N-1: transition to SORT with cnt=0 on the same edge.
REQ-018 SORT: in_ready=0, busy=1; each cycle SHALL perform one odd-even transposition pass over the register array, then increment cnt.
REQ-019 Even pass (cnt even): compare-swap pairs (0,1),(2,3),...,(N-2,N-1); odd pass: pairs (1,2),(3,4),...,(N-3,N-2); slot 0 and slot N-1 SHALL be untouched in odd passes.
REQ-020 Compare-swap: dir=0 swaps when a[k]>a[k+1]; dir=1 swaps when a[k]<a[k+1]; equal values SHALL NOT swap.
REQ-021 After exactly N passes (pass cnt=N-1 completes) transition to DRAIN with cnt=0; result SHALL be fully sorted for all inputs.
REQ-022 DRAIN: out_valid=1, out_data=a[cnt], in_ready=0; on out_ready=1 increment cnt; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 DRAIN, accept with cnt=N-1: done=1 for that cycle (registered, asserted the following cycle for exactly one cycle is NOT permitted -- done SHALL be combinational from state, cnt and out_ready), transition to LOAD, cnt=0.
REQ-024 Latency: last input accepted at edge T; SORT occupies cycles T..T+N-1; out_valid SHALL first be 1 in the cycle after edge T+N.
REQ-025 Input valid while not in LOAD SHALL be ignored (no storage, no state change); out_ready outside DRAIN SHALL be ignored.
REQ-026 No back-to-back overlap: the next block's first element SHALL be accepted no earlier than the cycle after done.

Reset
REQ-027 rst=1 SHALL immediately force state LOAD, cnt=0, dir=0, all array slots 0; outputs: in_ready=1, out_valid=0, out_data=0, busy=0, done=0.
REQ-028 Reset asserted mid-SORT or mid-DRAIN SHALL discard the partial block; after release the first accepted element is slot 0.

Verification
REQ-029 N=8, desc=0, in 5,3,8,1,9,2,7,4 continuous valid -> busy high 8 cycles, out 1,2,3,4,5,7,8,9, done on 9-accept.
REQ-030 Same data, desc=1 on first beat, desc toggled on later beats -> out 9,8,7,5,4,3,2,1.
REQ-031 Duplicates and extremes 255,0,255,0,128,128,1,254 ascending -> 0,0,1,128,128,254,255,255.
REQ-032 Random in_valid gaps and out_ready stalls (50%) -> same sorted order, out_data stable during stall, no element lost or duplicated, in_valid during SORT/DRAIN ignored.
REQ-033 rst pulsed at 3rd SORT cycle -> all outputs at reset values; next block 8,7,6,5,4,3,2,1 -> out 1..8.
REQ-034 Already-sorted input 1..8 and reverse-sorted 8..1 ascending -> both yield 1..8 at latency per REQ-024.
